// File: rtl/cic_interp_stage.sv
// N-stage CIC interpolator (ratio 2**LOG2R, M = 1) fed by single-cycle sample strobes.
// Define CIC_ROUND_EN for round-half-up with saturation and one extra output register stage.
module cic_interp_stage #(
    parameter int DW      = 16,
    parameter int N       = 3,
    parameter int LOG2R   = 3,
    parameter int OUT_DIV = 4
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          clr_ovr,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy,
    output logic          overrun
);

    localparam int W     = DW + N * LOG2R;
    localparam int R     = 1 << LOG2R;
    localparam int SH    = (N - 1) * LOG2R;
    localparam int DIV_W = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [W-1:0]       comb_dly   [N];
    logic [W-1:0]       comb_stage [N+1];
    logic [W-1:0]       comb_out;
    logic [W-1:0]       integ      [N];
    logic [W-1:0]       integ_next [N];
    logic [W-1:0]       integ_x;
    logic [DW-1:0]      pend;
    logic               pend_full;
    logic [DW-1:0]      comb_in;
    logic [LOG2R-1:0]   phase;
    logic [DIV_W-1:0]   divider;
    logic               tick, last_tick;
    logic               accept, src_pend, store_pend, drop;

    assign tick      = (state == RUN) && (divider == '0);
    assign last_tick = tick && (phase == LOG2R'(R - 1));
    assign busy      = (state == RUN);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        src_pend   = 1'b0;
        store_pend = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_tick) begin
                    if (pend_full) begin
                        accept   = 1'b1;
                        src_pend = 1'b1;
                        drop     = din_valid;
                    end else if (din_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (din_valid) begin
                    if (pend_full) drop = 1'b1;
                    else           store_pend = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Comb chain at input rate and integrator chain at output rate, both pure combinational.
    always_comb begin
        comb_in       = src_pend ? pend : din;
        comb_stage[0] = {{(W-DW){comb_in[DW-1]}}, comb_in};
        for (int k = 1; k <= N; k++)
            comb_stage[k] = comb_stage[k-1] - comb_dly[k-1];
        integ_x       = (phase == '0) ? comb_out : '0;
        integ_next[0] = integ[0] + integ_x;
        for (int k = 1; k < N; k++)
            integ_next[k] = integ[k] + integ_next[k-1];
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= IDLE;
            comb_out  <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            phase     <= '0;
            divider   <= '0;
            overrun   <= 1'b0;
            // NOTE: delay lines are a handful of registers, so they are reset like any other state.
            for (int k = 0; k < N; k++) begin
                comb_dly[k] <= '0;
                integ[k]    <= '0;
            end
        end else begin
            state <= state_next;

            if (state == RUN)
                divider <= (divider == DIV_W'(OUT_DIV - 1)) ? '0 : divider + 1'b1;
            else
                divider <= '0;

            if (tick) begin
                for (int k = 0; k < N; k++) integ[k] <= integ_next[k];
                phase <= phase + 1'b1;
            end

            if (accept) begin
                for (int k = 0; k < N; k++) comb_dly[k] <= comb_stage[k];
                comb_out <= comb_stage[N];
                phase    <= '0;
            end

            if (store_pend) begin
                pend      <= din;
                pend_full <= 1'b1;
            end else if (src_pend) begin
                pend_full <= 1'b0;
            end

            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

`ifdef CIC_ROUND_EN
    // Keep the bit just below the output LSB: floor(y/2**SH + 1/2) = floor(y/2**SH) + y[SH-1].
    localparam int K = W - SH;
    logic [K:0] out_hi;
    logic [K:0] rq;
    logic       out_stb;
    logic       sat;

    assign rq  = {out_hi[K], out_hi[K:1]} + (K + 1)'(out_hi[0]);
    assign sat = !rq[K] && (|rq[K-1:DW-1]);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            out_hi     <= '0;
            out_stb    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            out_stb    <= tick;
            if (tick) out_hi <= integ_next[N-1][W-1:SH-1];
            dout_valid <= out_stb;
            if (out_stb) dout <= sat ? {1'b0, {(DW-1){1'b1}}} : rq[DW-1:0];
        end
    end
`else
    always_ff @(posedge sysclk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= tick;
            if (tick) dout <= integ_next[N-1][SH +: DW];
        end
    end
`endif

endmodule

// File: tb/tb_cic_interp_stage.sv
// Self-checking bench for cic_interp_stage: direct-convolution scoreboard plus table-driven DC steps
// and hand-written sequences for reset, impulse, pending/overrun and mid-run reset.
module tb_cic_interp_stage;

    localparam int DW      = 16;
    localparam int N       = 3;
    localparam int LOG2R   = 3;
    localparam int OUT_DIV = 4;
    localparam int R       = 1 << LOG2R;
    localparam int SH      = (N - 1) * LOG2R;
`ifdef CIC_ROUND_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          clr_ovr = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          overrun;

    cic_interp_stage #(.DW(DW), .N(N), .LOG2R(LOG2R), .OUT_DIV(OUT_DIV)) dut (
        .sysclk(sysclk), .rst(rst), .din(din), .din_valid(din_valid), .clr_ovr(clr_ovr),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: output = zero-stuffed input convolved with (R-box)^N, scaled by 2**-SH.
    int h[$];
    int xs[$];
    int ntick = 0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] scale(input int y);
        int q;
`ifdef CIC_ROUND_EN
        q = (y >>> SH) + ((y >>> (SH - 1)) & 1);
        if (q > 32767) q = 32767;
`else
        q = y >>> SH;
`endif
        return q[DW-1:0];
    endfunction

    function automatic void push_sample(input logic [DW-1:0] v);
        int y;
        int m;
        xs.push_back(int'($signed(v)));
        for (int j = 0; j < R; j++) begin
            y = 0;
            for (int k = 0; k < h.size(); k++) begin
                m = ntick - k;
                if (m >= 0 && (m % R) == 0) y += h[k] * xs[m / R];
            end
            exp_q.push_back(scale(y));
            ntick++;
        end
    endfunction

    function automatic void model_reset();
        xs.delete();
        exp_q.delete();
        ntick = 0;
    endfunction

    // Output monitor: every dout_valid pops one expected value; times and values logged for sequences.
    logic [DW-1:0] vq[$];
    int            vt[$];
    always @(negedge sysclk) begin
        if (dout_valid === 1'b1) begin
            vq.push_back(dout);
            vt.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_dout_valid", 32'(dout), 32'hDEAD_BEEF);
            else                   check("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [DW-1:0] v, input bit accepted);
        din       = v;
        din_valid = 1'b1;
        if (accepted) push_sample(v);
        @(negedge sysclk);
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        model_reset();
        repeat (cycles) @(negedge sysclk);
        rst = 1'b0;
        vq.delete();
        vt.delete();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sysclk);
    endtask

    typedef struct {
        logic [DW-1:0] din;
        int            reps;
        logic [DW-1:0] settle;
    } vec_t;

    vec_t tbl[5];
    logic [DW-1:0] imp_exp[22];

    initial begin
        int t0;
        int bad;
        int sum;
        int tmp[$];

        // Build the (R-box)^N impulse response.
        h = '{1};
        for (int s = 0; s < N; s++) begin
            tmp.delete();
            for (int i = 0; i < h.size() + R - 1; i++) tmp.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R; j++) tmp[i + j] += h[i];
            h = tmp;
        end

        tbl[0] = '{16'h1000, 10, 16'h1000};
        tbl[1] = '{16'h8000,  6, 16'h8000};
        tbl[2] = '{16'h7FFF,  6, 16'h7FFF};
        tbl[3] = '{16'hFFFF,  5, 16'hFFFF};
        tbl[4] = '{16'h0000,  5, 16'h0000};
        imp_exp = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

        // 1. Reset held for 3 cycles with din_valid toggling.
        rst = 1'b1;
        @(negedge sysclk);
        for (int i = 0; i < 3; i++) begin
            din_valid = ~din_valid;
            din       = 16'h1234;
            @(negedge sysclk);
            check("rst_dout", 32'(dout), 0);
            check("rst_dout_valid", 32'(dout_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_overrun", 32'(overrun), 0);
        end
        din_valid = 1'b0;
        din       = '0;
        do_reset(1);
        repeat (20) @(negedge sysclk);
        check("no_output_before_input", 32'(vq.size()), 0);
        check("idle_busy", 32'(busy), 0);

        // 2/4. Table-driven DC steps, one input every 64 cycles.
        foreach (tbl[e]) begin
            for (int i = 0; i < tbl[e].reps; i++) begin
                vq.delete();
                vt.delete();
                t0 = cyc;
                send(tbl[e].din, 1'b1);
                wait_until(t0 + 64);
                check("dc_count", 32'(vq.size()), 32'(R));
                if (vq.size() == R) begin
                    check("dc_latency", 32'(vt[0] - t0), 32'(LAT));
                    bad = 0;
                    for (int j = 1; j < R; j++) if (vt[j] - vt[j-1] != OUT_DIV) bad++;
                    check("dc_spacing", 32'(bad), 0);
                    if (i >= 3) begin
                        bad = 0;
                        for (int j = 0; j < R; j++) if (vq[j] !== tbl[e].settle) bad++;
                        check("dc_settled", 32'(bad), 0);
                    end
                end
            end
        end

        // 3. Impulse from cleared state.
        do_reset(2);
        send(16'h0040, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_until(cyc + 63);
            send(16'h0000, 1'b1);
        end
        wait_until(cyc + 64);
        check("imp_count", 32'(vq.size()), 32'(4 * R));
        if (vq.size() == 4 * R) begin
            bad = 0;
            sum = 0;
            for (int j = 0; j < 22; j++) begin
                if (vq[j] !== imp_exp[j]) bad++;
                sum += int'(vq[j]);
            end
            for (int j = 22; j < 4 * R; j++) if (vq[j] !== 16'h0000) bad++;
            check("imp_shape", 32'(bad), 0);
            check("imp_sum", 32'(sum), 512);
        end

        // 5. Pending and overrun: strobes at relative cycles 0, 2, 4.
        do_reset(2);
        check("ovr_clear_after_rst", 32'(overrun), 0);
        @(negedge sysclk);
        send(16'h0100, 1'b1);
        @(negedge sysclk);
        send(16'h0200, 1'b1);
        @(negedge sysclk);
        send(16'h0300, 1'b0);
        check("ovr_set", 32'(overrun), 1);
        wait_until(cyc + 80);
        check("ovr_sticky", 32'(overrun), 1);
        check("ovr_count", 32'(vq.size()), 32'(2 * R));
        if (vq.size() == 2 * R) check("ovr_back_to_back", 32'(vt[R] - vt[R-1]), 32'(OUT_DIV));
        clr_ovr = 1'b1;
        @(negedge sysclk);
        clr_ovr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // Strobe on the last tick with pending empty is taken directly.
        vq.delete();
        vt.delete();
        t0 = cyc;
        send(16'h0400, 1'b1);
        wait_until(t0 + 1 + (R - 1) * OUT_DIV);
        check("lastk_busy", 32'(busy), 1);
        send(16'h0500, 1'b1);
        wait_until(cyc + 60);
        check("lastk_count", 32'(vq.size()), 32'(2 * R));
        if (vq.size() == 2 * R) check("lastk_span", 32'(vt[2*R-1] - vt[0]), 32'((2 * R - 1) * OUT_DIV));
        check("lastk_no_overrun", 32'(overrun), 0);
        check("lastk_idle", 32'(busy), 0);

        // 6. Reset mid-run, after the phase-3 output.
        t0 = cyc;
        send(16'h1000, 1'b1);
        wait_until(t0 + LAT + 3 * OUT_DIV + 1);
        rst = 1'b1;
        model_reset();
        @(negedge sysclk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_dout", 32'(dout), 0);
        check("midrst_dout_valid", 32'(dout_valid), 0);
        rst = 1'b0;
        vq.delete();
        vt.delete();
        repeat (3) @(negedge sysclk);
        t0 = cyc;
        send(16'h1000, 1'b1);
        wait_until(t0 + 64);
        check("midrst_count", 32'(vq.size()), 32'(R));
        if (vq.size() == R) begin
            check("midrst_first", 32'(vq[0]), 32'h0040);
            check("midrst_latency", 32'(vt[0] - t0), 32'(LAT));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
